// File: rtl/dcache_control_nway.sv
// dcache_control_nway
//   N-way set-associative write-back / write-allocate data-cache controller.
//   It sits between the CPU data port and the cacheline adaptor. It drives the
//   tag/valid/dirty/data arrays of an external datapath and updates an
//   external pseudo-LRU array.
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   mem_read/mem_write   CPU request, held until mem_resp (a write wins if both are set)
//   mem_byte_enable256   CPU write byte mask, line-aligned
//   mem_resp             one-cycle completion pulse
//   hit/valid_out/dirty_out  per-way status of the indexed set
//   plru_victim          PLRU choice used when every way is valid
//   plru_load/plru_way   PLRU update strobe and most-recently-used way
//   load_*/set_*         one-hot array write strobes and write values
//   data_we/data_wmask   data-array write enable and byte mask
//   data_in_sel          data source: 0 = CPU, 1 = pmem line
//   pmem_addr_sel        pmem address source: 0 = CPU tag, 1 = victim tag
//   victim_way           victim way latched at the miss
//   pmem_read/pmem_write/pmem_resp  cacheline adaptor handshake
//   err_multihit         sticky flag: more than one hit bit was seen
//   hit_count/miss_count/wb_count  saturating performance counters
module dcache_control_nway #(
  parameter int unsigned WAYS       = 4,
  parameter int unsigned WAY_W      = $clog2(WAYS),
  parameter int unsigned LINE_BYTES = 32,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [LINE_BYTES-1:0] mem_byte_enable256,
  output logic                  mem_resp,
  input  logic [WAYS-1:0]       hit,
  input  logic [WAYS-1:0]       valid_out,
  input  logic [WAYS-1:0]       dirty_out,
  input  logic [WAY_W-1:0]      plru_victim,
  output logic                  plru_load,
  output logic [WAY_W-1:0]      plru_way,
  output logic [WAYS-1:0]       load_tag,
  output logic [WAYS-1:0]       load_valid,
  output logic [WAYS-1:0]       set_valid,
  output logic [WAYS-1:0]       load_dirty,
  output logic [WAYS-1:0]       set_dirty,
  output logic [WAYS-1:0]       data_we,
  output logic [LINE_BYTES-1:0] data_wmask,
  output logic                  data_in_sel,
  output logic                  pmem_addr_sel,
  output logic [WAY_W-1:0]      victim_way,
  output logic                  pmem_read,
  output logic                  pmem_write,
  input  logic                  pmem_resp,
  output logic                  err_multihit,
  output logic [CNT_W-1:0]      hit_count,
  output logic [CNT_W-1:0]      miss_count,
  output logic [CNT_W-1:0]      wb_count
);

  typedef enum logic [1:0] {
    S_COMPARE,
    S_WB,
    S_FILL,
    S_REPLAY
  } state_t;

  state_t state, state_n;

  logic [WAY_W-1:0] victim_q;
  logic             req;
  logic             hit_any;
  logic             multi_hit;
  logic [WAY_W-1:0] hit_way;
  logic             hit_found;
  logic [WAY_W-1:0] miss_victim;
  logic             inv_found;
  logic             victim_dirty;
  logic [WAYS-1:0]  hit_oh;
  logic [WAYS-1:0]  victim_oh;
  logic             hit_evt;
  logic             miss_evt;
  logic             wb_evt;

  assign req       = mem_read | mem_write;
  assign hit_any   = |hit;
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_hit = (hit & (hit - WAYS'(1))) != '0;
  assign hit_oh    = WAYS'(1) << hit_way;
  assign victim_oh = WAYS'(1) << victim_q;

  assign hit_evt   = (state == S_COMPARE) && req && hit_any;
  assign miss_evt  = (state == S_COMPARE) && req && !hit_any;
  assign wb_evt    = (state == S_WB) && pmem_resp;

  assign victim_way = victim_q;

  // Lowest-index hit way; a multi-hit also resolves to the lowest index.
  always_comb begin
    hit_way   = '0;
    hit_found = 1'b0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (hit[i] && !hit_found) begin
        hit_way   = WAY_W'(i);
        hit_found = 1'b1;
      end
    end
  end

  // Victim choice: the first invalid way, or the PLRU way when the set is full.
  always_comb begin
    miss_victim = plru_victim;
    inv_found   = 1'b0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (!valid_out[i] && !inv_found) begin
        miss_victim = WAY_W'(i);
        inv_found   = 1'b1;
      end
    end
    victim_dirty = valid_out[miss_victim] & dirty_out[miss_victim];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_COMPARE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n       = state;
    mem_resp      = 1'b0;
    plru_load     = 1'b0;
    plru_way      = '0;
    load_tag      = '0;
    load_valid    = '0;
    set_valid     = '0;
    load_dirty    = '0;
    set_dirty     = '0;
    data_we       = '0;
    data_wmask    = '0;
    data_in_sel   = 1'b0;
    pmem_addr_sel = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;

    unique case (state)
      S_COMPARE: begin
        if (req) begin
          if (hit_any) begin
            mem_resp  = 1'b1;
            plru_load = 1'b1;
            plru_way  = hit_way;
            if (mem_write) begin
              data_we    = hit_oh;
              data_wmask = mem_byte_enable256;
              load_dirty = hit_oh;
              set_dirty  = hit_oh;
            end
          end else begin
            state_n = victim_dirty ? S_WB : S_FILL;
          end
        end
      end
      S_WB: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = 1'b1;
        if (pmem_resp) begin
          load_dirty = victim_oh;
          state_n    = S_FILL;
        end
      end
      S_FILL: begin
        pmem_read   = 1'b1;
        data_in_sel = 1'b1;
        if (pmem_resp) begin
          data_we    = victim_oh;
          data_wmask = '1;
          load_tag   = victim_oh;
          load_valid = victim_oh;
          set_valid  = victim_oh;
          load_dirty = victim_oh;
          state_n    = S_REPLAY;
        end
      end
      S_REPLAY: begin
        state_n = S_COMPARE;
      end
      default: state_n = S_COMPARE;
    endcase

    // Outputs are decoded from state and live inputs, so reset must also
    // mask them combinationally to drop pmem strobes the instant it asserts.
    if (rst) begin
      mem_resp      = 1'b0;
      plru_load     = 1'b0;
      plru_way      = '0;
      load_tag      = '0;
      load_valid    = '0;
      set_valid     = '0;
      load_dirty    = '0;
      set_dirty     = '0;
      data_we       = '0;
      data_wmask    = '0;
      data_in_sel   = 1'b0;
      pmem_addr_sel = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      victim_q     <= '0;
      err_multihit <= 1'b0;
      hit_count    <= '0;
      miss_count   <= '0;
      wb_count     <= '0;
    end else begin
      if (miss_evt) begin
        victim_q <= miss_victim;
      end
      if (state == S_COMPARE && req && multi_hit) begin
        err_multihit <= 1'b1;
      end
      if (hit_evt && hit_count != '1) begin
        hit_count <= hit_count + CNT_W'(1);
      end
      if (miss_evt && miss_count != '1) begin
        miss_count <= miss_count + CNT_W'(1);
      end
      if (wb_evt && wb_count != '1) begin
        wb_count <= wb_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dcache_control_nway.sv
module tb_dcache_control_nway;

  localparam int unsigned WAYS  = 4;
  localparam int unsigned WAY_W = 2;
  localparam int unsigned LB    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_read, mem_write;
  logic [LB-1:0] mem_byte_enable256;
  logic [3:0]    hit, valid_out, dirty_out;
  logic [1:0]    plru_victim;
  logic          pmem_resp;

  logic          mem_resp, plru_load, data_in_sel, pmem_addr_sel, pmem_read, pmem_write, err_multihit;
  logic [1:0]    plru_way, victim_way;
  logic [3:0]    load_tag, load_valid, set_valid, load_dirty, set_dirty, data_we;
  logic [LB-1:0] data_wmask;
  logic [31:0]   hit_count, miss_count, wb_count;

  logic          mem_resp_4, plru_load_4, data_in_sel_4, pmem_addr_sel_4, pmem_read_4, pmem_write_4, err_multihit_4;
  logic [1:0]    plru_way_4, victim_way_4;
  logic [3:0]    load_tag_4, load_valid_4, set_valid_4, load_dirty_4, set_dirty_4, data_we_4;
  logic [LB-1:0] data_wmask_4;
  logic [3:0]    hit_count_4, miss_count_4, wb_count_4;

  always #5 clk = ~clk;

  dcache_control_nway #(.WAYS(WAYS), .LINE_BYTES(LB), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable256(mem_byte_enable256), .mem_resp(mem_resp), .hit(hit),
    .valid_out(valid_out), .dirty_out(dirty_out), .plru_victim(plru_victim),
    .plru_load(plru_load), .plru_way(plru_way), .load_tag(load_tag),
    .load_valid(load_valid), .set_valid(set_valid), .load_dirty(load_dirty),
    .set_dirty(set_dirty), .data_we(data_we), .data_wmask(data_wmask),
    .data_in_sel(data_in_sel), .pmem_addr_sel(pmem_addr_sel), .victim_way(victim_way),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .err_multihit(err_multihit), .hit_count(hit_count), .miss_count(miss_count),
    .wb_count(wb_count)
  );

  dcache_control_nway #(.WAYS(WAYS), .LINE_BYTES(LB), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable256(mem_byte_enable256), .mem_resp(mem_resp_4), .hit(hit),
    .valid_out(valid_out), .dirty_out(dirty_out), .plru_victim(plru_victim),
    .plru_load(plru_load_4), .plru_way(plru_way_4), .load_tag(load_tag_4),
    .load_valid(load_valid_4), .set_valid(set_valid_4), .load_dirty(load_dirty_4),
    .set_dirty(set_dirty_4), .data_we(data_we_4), .data_wmask(data_wmask_4),
    .data_in_sel(data_in_sel_4), .pmem_addr_sel(pmem_addr_sel_4), .victim_way(victim_way_4),
    .pmem_read(pmem_read_4), .pmem_write(pmem_write_4), .pmem_resp(pmem_resp),
    .err_multihit(err_multihit_4), .hit_count(hit_count_4), .miss_count(miss_count_4),
    .wb_count(wb_count_4)
  );

  typedef struct packed {
    logic [1:0]    way;
    logic          wr;
    logic [LB-1:0] mask;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_hit  = 0;
  int   exp_miss = 0;
  int   exp_wb   = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    mem_read = 1'b0; mem_write = 1'b0; hit = 4'b0; pmem_resp = 1'b0;
  endtask

  // Waits (bounded) for mem_resp; the caller has already advanced one tick
  // into the cycle it expects the response in or earlier.
  task automatic wait_resp(output bit got);
    got = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick; #1;
      if (mem_resp === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; mem_read = 1'b1; mem_write = 1'b0; hit = 4'b0001; pmem_resp = 1'b0;
    mem_byte_enable256 = '0; valid_out = 4'hF; dirty_out = 4'h0; plru_victim = 2'd0;
    #2;
    n_checks++;
    if ({mem_resp, plru_load, pmem_read, pmem_write, data_we, load_tag, load_dirty} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got resp=%b plru=%b we=%b want all 0", mem_resp, plru_load, data_we);
    end
    n_checks++;
    if ({hit_count, miss_count, wb_count, victim_way, err_multihit} !== '0) begin
      n_fail++; $display("FAIL reset_state got hc=%0d mc=%0d wc=%0d vw=%0d err=%b want 0", hit_count, miss_count, wb_count, victim_way, err_multihit);
    end
    idle_inputs;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_read_hit;
    exp_t e;
    tick;
    mem_read = 1'b1; hit = 4'b0100; valid_out = 4'hF;
    sb.push_back('{way: 2'd2, wr: 1'b0, mask: '0});
    #1;
    n_checks++;
    if (mem_resp !== 1'b1) begin
      n_fail++; $display("FAIL read_hit_resp got %b want 1", mem_resp);
    end else begin
      e = sb.pop_front(); exp_hit++;
      n_checks++;
      if ({plru_load, plru_way, data_we, data_wmask, load_dirty} !== {1'b1, e.way, 4'b0, 32'b0, 4'b0}) begin
        n_fail++; $display("FAIL read_hit_fields got plru=%b way=%0d we=%b want 1/%0d/0000", plru_load, plru_way, data_we, e.way);
      end
    end
    tick;
    idle_inputs;
    #1;
    n_checks++;
    if (hit_count !== 32'(exp_hit)) begin
      n_fail++; $display("FAIL read_hit_count got %0d want %0d", hit_count, exp_hit);
    end
  endtask

  task automatic test_write_hit;
    exp_t e;
    logic [3:0] ew;
    tick;
    mem_write = 1'b1; hit = 4'b0001; mem_byte_enable256 = 32'h0000_00F0;
    sb.push_back('{way: 2'd0, wr: 1'b1, mask: 32'h0000_00F0});
    #1;
    n_checks++;
    if (mem_resp !== 1'b1) begin
      n_fail++; $display("FAIL write_hit_resp got %b want 1", mem_resp);
    end else begin
      e = sb.pop_front(); exp_hit++;
      ew = 4'b1 << e.way;
      n_checks++;
      if ({plru_load, plru_way, data_we, data_wmask, load_dirty, set_dirty, data_in_sel} !== {1'b1, e.way, ew, e.mask, ew, ew, 1'b0}) begin
        n_fail++; $display("FAIL write_hit_fields got we=%b mask=%h ld=%b sd=%b want %b %h %b %b", data_we, data_wmask, load_dirty, set_dirty, ew, e.mask, ew, ew);
      end
    end
    tick;
    idle_inputs;
  endtask

  task automatic test_clean_miss;
    exp_t e;
    bit got;
    tick;
    mem_read = 1'b1; hit = 4'b0; valid_out = 4'b1011; dirty_out = 4'b1011; plru_victim = 2'd0;
    sb.push_back('{way: 2'd2, wr: 1'b0, mask: '0});
    exp_miss++;
    #1;
    n_checks++;
    if ({mem_resp, pmem_read, pmem_write} !== 3'b000) begin
      n_fail++; $display("FAIL clean_miss_compare got resp=%b pr=%b pw=%b want 000", mem_resp, pmem_read, pmem_write);
    end
    tick; #1;
    n_checks++;
    if ({pmem_read, pmem_write, data_in_sel, pmem_addr_sel, victim_way, mem_resp} !== {4'b1010, 2'd2, 1'b0}) begin
      n_fail++; $display("FAIL clean_miss_fill got pr=%b pw=%b dsel=%b asel=%b vw=%0d want 1 0 1 0 2", pmem_read, pmem_write, data_in_sel, pmem_addr_sel, victim_way);
    end
    n_checks++;
    if (miss_count !== 32'(exp_miss)) begin
      n_fail++; $display("FAIL clean_miss_count got %0d want %0d", miss_count, exp_miss);
    end
    repeat (4) tick;
    pmem_resp = 1'b1;
    #1;
    n_checks++;
    if ({load_tag, load_valid, set_valid, data_we, data_wmask, load_dirty, set_dirty, mem_resp} !== {4'b0100, 4'b0100, 4'b0100, 4'b0100, 32'hFFFF_FFFF, 4'b0100, 4'b0000, 1'b0}) begin
      n_fail++; $display("FAIL clean_miss_fill_done got lt=%b sv=%b we=%b mask=%h ld=%b sd=%b want 0100 0100 0100 ffffffff 0100 0000", load_tag, set_valid, data_we, data_wmask, load_dirty, set_dirty);
    end
    tick;
    pmem_resp = 1'b0; hit = 4'b0100; valid_out = 4'hF;
    #1;
    n_checks++;
    if ({mem_resp, data_we, load_tag, load_valid, load_dirty, pmem_read, pmem_write} !== '0) begin
      n_fail++; $display("FAIL clean_miss_replay got resp=%b we=%b lt=%b pr=%b want all 0", mem_resp, data_we, load_tag, pmem_read);
    end
    wait_resp(got);
    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL clean_miss_timeout got no mem_resp want mem_resp");
    end else begin
      e = sb.pop_front(); exp_hit++;
      n_checks++;
      if ({plru_load, plru_way, data_we} !== {1'b1, e.way, 4'b0}) begin
        n_fail++; $display("FAIL clean_miss_replay_hit got way=%0d we=%b want %0d 0000", plru_way, data_we, e.way);
      end
    end
    tick;
    idle_inputs;
    #1;
    n_checks++;
    if ({hit_count, miss_count} !== {32'(exp_hit), 32'(exp_miss)}) begin
      n_fail++; $display("FAIL clean_miss_counters got hc=%0d mc=%0d want %0d %0d", hit_count, miss_count, exp_hit, exp_miss);
    end
  endtask

  task automatic test_dirty_miss;
    exp_t e;
    bit got;
    logic [3:0] ew;
    tick;
    mem_write = 1'b1; mem_byte_enable256 = 32'hFF00_0000; hit = 4'b0;
    valid_out = 4'hF; dirty_out = 4'b1000; plru_victim = 2'd3;
    sb.push_back('{way: 2'd3, wr: 1'b1, mask: 32'hFF00_0000});
    exp_miss++;
    #1;
    n_checks++;
    if (mem_resp !== 1'b0) begin
      n_fail++; $display("FAIL dirty_miss_compare got resp=%b want 0", mem_resp);
    end
    tick; #1;
    n_checks++;
    if ({pmem_write, pmem_addr_sel, pmem_read, victim_way, mem_resp} !== {3'b110, 2'd3, 1'b0}) begin
      n_fail++; $display("FAIL dirty_miss_wb got pw=%b asel=%b pr=%b vw=%0d want 1 1 0 3", pmem_write, pmem_addr_sel, pmem_read, victim_way);
    end
    repeat (2) tick;
    pmem_resp = 1'b1;
    #1;
    n_checks++;
    if ({load_dirty, set_dirty, data_we, mem_resp} !== {4'b1000, 4'b0000, 4'b0000, 1'b0}) begin
      n_fail++; $display("FAIL dirty_miss_wb_done got ld=%b sd=%b we=%b want 1000 0000 0000", load_dirty, set_dirty, data_we);
    end
    exp_wb++;
    tick;
    pmem_resp = 1'b0;
    #1;
    n_checks++;
    if ({pmem_read, pmem_write, pmem_addr_sel, wb_count} !== {3'b100, 32'(exp_wb)}) begin
      n_fail++; $display("FAIL dirty_miss_fill got pr=%b pw=%b asel=%b wc=%0d want 1 0 0 %0d", pmem_read, pmem_write, pmem_addr_sel, wb_count, exp_wb);
    end
    tick;
    pmem_resp = 1'b1;
    #1;
    n_checks++;
    if ({load_tag, set_valid, data_we} !== {4'b1000, 4'b1000, 4'b1000}) begin
      n_fail++; $display("FAIL dirty_miss_fill_done got lt=%b sv=%b we=%b want 1000 1000 1000", load_tag, set_valid, data_we);
    end
    tick;
    pmem_resp = 1'b0; hit = 4'b1000; dirty_out = 4'b0000;
    #1;
    n_checks++;
    if ({mem_resp, data_we, pmem_read, pmem_write} !== '0) begin
      n_fail++; $display("FAIL dirty_miss_replay got resp=%b we=%b want 0 0000", mem_resp, data_we);
    end
    wait_resp(got);
    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL dirty_miss_timeout got no mem_resp want mem_resp");
    end else begin
      e = sb.pop_front(); exp_hit++;
      ew = 4'b1 << e.way;
      n_checks++;
      if ({plru_way, data_we, data_wmask, set_dirty} !== {e.way, ew, e.mask, ew}) begin
        n_fail++; $display("FAIL dirty_miss_replay_hit got way=%0d we=%b mask=%h sd=%b want %0d %b %h %b", plru_way, data_we, data_wmask, set_dirty, e.way, ew, e.mask, ew);
      end
    end
    tick;
    idle_inputs;
  endtask

  task automatic test_multihit;
    exp_t e;
    tick;
    mem_read = 1'b1; hit = 4'b0110; valid_out = 4'hF;
    sb.push_back('{way: 2'd1, wr: 1'b0, mask: '0});
    #1;
    n_checks++;
    if (mem_resp !== 1'b1) begin
      n_fail++; $display("FAIL multihit_resp got %b want 1", mem_resp);
    end else begin
      e = sb.pop_front(); exp_hit++;
      n_checks++;
      if ({plru_load, plru_way} !== {1'b1, e.way}) begin
        n_fail++; $display("FAIL multihit_way got %0d want %0d", plru_way, e.way);
      end
    end
    tick;
    hit = 4'b0001;
    exp_hit++;
    #1;
    n_checks++;
    if (err_multihit !== 1'b1) begin
      n_fail++; $display("FAIL multihit_flag got %b want 1", err_multihit);
    end
    tick;
    idle_inputs;
    #1;
    n_checks++;
    if ({err_multihit, hit_count} !== {1'b1, 32'(exp_hit)}) begin
      n_fail++; $display("FAIL multihit_sticky got err=%b hc=%0d want 1 %0d", err_multihit, hit_count, exp_hit);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   sat4;
    for (int i = 0; i < 20; i++) begin
      tick;
      mem_read = 1'b1; hit = 4'b1 << (i % 4);
      sb.push_back('{way: 2'(i % 4), wr: 1'b0, mask: '0});
      #1;
      n_checks++;
      if (mem_resp !== 1'b1) begin
        n_fail++; $display("FAIL b2b_resp_%0d got %b want 1", i, mem_resp);
      end else begin
        e = sb.pop_front(); exp_hit++;
        n_checks++;
        if (plru_way !== e.way) begin
          n_fail++; $display("FAIL b2b_way_%0d got %0d want %0d", i, plru_way, e.way);
        end
      end
    end
    tick;
    idle_inputs;
    #1;
    sat4 = (exp_hit > 15) ? 15 : exp_hit;
    n_checks++;
    if ({hit_count_4, miss_count_4, wb_count_4} !== {4'(sat4), 4'(exp_miss), 4'(exp_wb)}) begin
      n_fail++; $display("FAIL sat4_counters got hc=%0d mc=%0d wc=%0d want %0d %0d %0d", hit_count_4, miss_count_4, wb_count_4, sat4, exp_miss, exp_wb);
    end
    n_checks++;
    if (hit_count !== 32'(exp_hit)) begin
      n_fail++; $display("FAIL b2b_hit_count got %0d want %0d", hit_count, exp_hit);
    end
  endtask

  task automatic test_reset_mid_fill;
    exp_t e;
    tick;
    mem_read = 1'b1; hit = 4'b0; valid_out = 4'b0111; dirty_out = 4'b0111;
    tick; #1;
    n_checks++;
    if ({pmem_read, victim_way} !== {1'b1, 2'd3}) begin
      n_fail++; $display("FAIL rst_fill_entry got pr=%b vw=%0d want 1 3", pmem_read, victim_way);
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({pmem_read, pmem_write, data_in_sel, mem_resp} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_fill_drop got pr=%b pw=%b dsel=%b want 0 0 0", pmem_read, pmem_write, data_in_sel);
    end
    n_checks++;
    if ({hit_count, miss_count, wb_count, victim_way, err_multihit} !== '0) begin
      n_fail++; $display("FAIL rst_fill_state got hc=%0d mc=%0d wc=%0d vw=%0d err=%b want 0", hit_count, miss_count, wb_count, victim_way, err_multihit);
    end
    idle_inputs;
    tick;
    rst = 1'b0;
    tick; #1;
    n_checks++;
    if ({pmem_read, pmem_write, hit_count, miss_count, wb_count} !== '0) begin
      n_fail++; $display("FAIL rst_fill_release got pr=%b hc=%0d mc=%0d wc=%0d want 0", pmem_read, hit_count, miss_count, wb_count);
    end
    // A hit right after release proves the controller came back in COMPARE.
    mem_read = 1'b1; hit = 4'b0010; valid_out = 4'hF;
    sb.push_back('{way: 2'd1, wr: 1'b0, mask: '0});
    #1;
    n_checks++;
    if (mem_resp !== 1'b1) begin
      n_fail++; $display("FAIL rst_fill_post_hit got %b want 1", mem_resp);
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (plru_way !== e.way) begin
        n_fail++; $display("FAIL rst_fill_post_way got %0d want %0d", plru_way, e.way);
      end
    end
    tick;
    idle_inputs;
    #1;
    n_checks++;
    if (hit_count !== 32'd1) begin
      n_fail++; $display("FAIL rst_fill_post_count got %0d want 1", hit_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset;
    test_read_hit;
    test_write_hit;
    test_clean_miss;
    test_dirty_miss;
    test_multihit;
    test_back_to_back;
    test_reset_mid_fill;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_control_nway.md
Name: dcache_control_nway

Overview:
- Parametrised N-way set-associative write-back/write-allocate data-cache controller.
- Sits between the CPU data port and the cacheline adaptor.
- Drives the tag, valid, dirty and data arrays of an external cache datapath and updates an external pseudo-LRU array.
- Beyond the 2-way controller it adds:
  - a WAYS parameter;
  - invalid-way-first victim selection with the victim latched at the miss;
  - a replay cycle after fill;
  - a sticky multi-hit error flag;
  - saturating hit, miss and writeback performance counters.

Parameters:
- WAYS, 4, number of ways; power of two, 2 to 16.
- WAY_W, $clog2(WAYS), width of a way index.
- LINE_BYTES, 32, bytes per cacheline; width of the byte mask.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_byte_enable256  in  LINE_BYTES  CPU write byte mask, line-aligned
- mem_resp  out  1  one-cycle request completion
- hit  in  WAYS  per-way tag match AND valid, from the datapath
- valid_out  in  WAYS  per-way valid bits of the indexed set
- dirty_out  in  WAYS  per-way dirty bits of the indexed set
- plru_victim  in  WAY_W  PLRU-selected victim for the indexed set
- plru_load  out  1  update the PLRU array for the indexed set
- plru_way  out  WAY_W  most-recently-used way for the PLRU update
- load_tag  out  WAYS  one-hot tag write
- load_valid  out  WAYS  one-hot valid write
- set_valid  out  WAYS  valid write value
- load_dirty  out  WAYS  one-hot dirty write
- set_dirty  out  WAYS  dirty write value
- data_we  out  WAYS  one-hot data-array write enable
- data_wmask  out  LINE_BYTES  data-array byte mask
- data_in_sel  out  1  data source: 0 = CPU, 1 = pmem line
- pmem_addr_sel  out  1  pmem address source: 0 = CPU tag, 1 = victim tag
- victim_way  out  WAY_W  latched victim; the datapath muxes the victim tag and data with it
- pmem_read  out  1  line read request
- pmem_write  out  1  line write request
- pmem_resp  in  1  cacheline adaptor completion
- err_multihit  out  1  sticky: more than one hit bit observed
- hit_count  out  CNT_W  saturating hit counter
- miss_count  out  CNT_W  saturating miss counter
- wb_count  out  CNT_W  saturating writeback counter

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - state goes to COMPARE; all outputs go to 0;
  - counters clear; victim register clears; err_multihit clears;
  - pmem_read and pmem_write drop in the same instant the reset asserts.
- Defaults: every output is 0 unless listed for the current state.
- Requests: req = mem_read | mem_write. If both are asserted, the request is a write.
- COMPARE, no req: idle; no outputs.
- COMPARE, req, |hit (h = index of the set hit bit):
  - mem_resp=1, plru_load=1, plru_way=h, hit_count+1;
  - write additionally: data_we[h]=1, data_wmask=mem_byte_enable256, data_in_sel=0, load_dirty[h]=1, set_dirty[h]=1;
  - 0-cycle latency: the response is in the same cycle as the request.
- COMPARE, req, hit==0 (miss):
  - victim = lowest-index way with valid_out==0; if all ways are valid, victim = plru_victim;
  - latch victim into victim_way;
  - miss_count+1;
  - next state: WB if the victim is valid and dirty, else FILL.
- WB:
  - pmem_write=1, pmem_addr_sel=1;
  - on pmem_resp: load_dirty[victim]=1, set_dirty[victim]=0, wb_count+1, next state FILL.
- FILL:
  - pmem_read=1, pmem_addr_sel=0, data_in_sel=1;
  - on pmem_resp: data_we[victim]=1, data_wmask all ones, load_tag[victim]=1, load_valid[victim]=1, set_valid[victim]=1, load_dirty[victim]=1, set_dirty[victim]=0, next state REPLAY.
- REPLAY:
  - one cycle with no array writes, so the arrays re-read the set;
  - next state COMPARE, where the request now hits and completes as a normal hit (counted as a hit as well).
  - Miss latency, clean victim: FILL-wait + 2 cycles. Dirty victim: WB-wait + FILL-wait + 2 cycles.
- Multi-hit: if more than one hit bit is set in COMPARE, err_multihit is set (sticky) and the lowest-index hit way is used.
- Request withdrawn while in WB or FILL: the sequence completes, then the block returns to COMPARE with no response.
- mem_resp never asserts in WB, FILL or REPLAY.
- Counters saturate at all ones; they never wrap.
- Counters increment only in the cycle of the counted event.

Test Plan:
- Read hit: WAYS=4, hit=4'b0100, mem_read -> same-cycle mem_resp=1, plru_load=1, plru_way=2, data_we=0, hit_count=1.
- Write hit: hit=4'b0001, mem_byte_enable256=32'h0000_00F0 -> data_we=4'b0001, data_wmask=32'h0000_00F0, load_dirty[0]=set_dirty[0]=1, mem_resp=1.
- Clean miss with an invalid way: valid_out=4'b1011, plru_victim=0 -> victim_way=2, FILL; pmem_resp after 5 cycles -> load_tag=4'b0100, set_valid[2]=1, then REPLAY, then hit and mem_resp; miss_count=1, hit_count=1.
- Dirty miss: valid_out=4'hF, dirty_out=4'b1000, plru_victim=3 -> WB with pmem_write=1 and pmem_addr_sel=1; pmem_resp -> dirty[3] cleared, wb_count=1; then FILL, REPLAY, COMPARE.
- Reset mid-FILL: assert rst with pmem_read=1 -> pmem_read=0 immediately; state COMPARE; all counters 0 after release.
- Edge cases:
  - hit=4'b0110 -> err_multihit=1 and stays set, plru_way=1;
  - CNT_W=4 with 20 hits -> hit_count=4'hF.
